// File: rtl/tx_buffer_pkg.sv
// rtl/tx_buffer_pkg.sv - shared widths and serialiser state encoding for tx_block_buffer
package tx_buffer_pkg;

  localparam int BLOCK_W         = 128;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_shift.sv
// rtl/tx_shift.sv - block-to-byte serialiser: shift register, byte counter and UART handshake FSM
// Byte order follows TX_BUFFER_LSB_FIRST_EN (defined: LSB byte first, undefined: MSB byte first).
module tx_shift
  import tx_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_fifo_empty,
  input  logic [BLOCK_W-1:0] i_head_block,
  input  logic               i_tx_done,
  output logic               o_pop,
  output logic               o_tx_start,
  output logic [BYTE_W-1:0]  o_byte,
  output logic               o_fsm_idle
);

  tx_state_t          r_state;
  tx_state_t          w_state_next;
  logic [BLOCK_W-1:0] r_shreg;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic               w_load;
  logic               w_shift;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    o_tx_start   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_fifo_empty) begin
          w_load       = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        o_tx_start   = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        // tx_done is only meaningful here; other states ignore it
        if (i_tx_done) begin
          if (r_byte_cnt == CNT_W'(BYTES_PER_BLOCK - 1)) begin
            w_state_next = IDLE;
          end else begin
            w_shift      = 1'b1;
            w_state_next = START;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg    <= '0;
      r_byte_cnt <= '0;
    end else if (w_load) begin
      r_shreg    <= i_head_block;
      r_byte_cnt <= '0;
    end else if (w_shift) begin
`ifdef TX_BUFFER_LSB_FIRST_EN
      r_shreg    <= r_shreg >> BYTE_W;
`else
      r_shreg    <= r_shreg << BYTE_W;
`endif
      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
    end
  end

`ifdef TX_BUFFER_LSB_FIRST_EN
  assign o_byte = r_shreg[BYTE_W-1:0];
`else
  assign o_byte = r_shreg[BLOCK_W-1 -: BYTE_W];
`endif

  assign o_pop      = w_load;
  assign o_fsm_idle = (r_state == IDLE);

endmodule

// File: rtl/tx_block_buffer.sv
// rtl/tx_block_buffer.sv - ciphertext block FIFO feeding a byte serialiser towards a UART transmitter
// Optional TX_BUFFER_LSB_FIRST_EN selects LSB-byte-first transmission (see tx_shift).
module tx_block_buffer
  import tx_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] block_aes_to_buffer,
  input  logic               write_en,
  output logic               full,
  output logic               overflow,
  output logic [BYTE_W-1:0]  byte_shiftReg_to_UART_tx,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               idle
);

  localparam int AW = $clog2(DEPTH);

  logic [BLOCK_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_overflow;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_fsm_idle;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop in the same cycle does not make room for a write that arrives while full
  assign w_push  = write_en && !w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= block_aes_to_buffer;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
      if (write_en && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  tx_shift u_tx_shift (
    .clk          (clk),
    .reset        (reset),
    .i_fifo_empty (w_empty),
    .i_head_block (r_mem[r_rd_ptr]),
    .i_tx_done    (tx_done),
    .o_pop        (w_pop),
    .o_tx_start   (tx_start),
    .o_byte       (byte_shiftReg_to_UART_tx),
    .o_fsm_idle   (w_fsm_idle)
  );

  assign full     = w_full;
  assign overflow = r_overflow;
  assign idle     = w_empty && w_fsm_idle;

endmodule

// File: tb/tb_tx_block_buffer.sv
// tb/tb_tx_block_buffer.sv - self-checking bench for tx_block_buffer (honours TX_BUFFER_LSB_FIRST_EN)
module tb_tx_block_buffer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] blk_in = '0;
  logic         write_en = 1'b0;
  logic         full, overflow, tx_start, tx_done, idle;
  logic [7:0]   byte_out;
  logic         done_resp = 1'b0;
  logic         done_man = 1'b0;

  assign tx_done = done_resp | done_man;

  tx_block_buffer #(.DEPTH(4)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .block_aes_to_buffer      (blk_in),
    .write_en                 (write_en),
    .full                     (full),
    .overflow                 (overflow),
    .byte_shiftReg_to_UART_tx (byte_out),
    .tx_start                 (tx_start),
    .tx_done                  (tx_done),
    .idle                     (idle)
  );

  always #5 clk = ~clk;

  localparam int INF = 1000000;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         starts_total = 0;
  int         last_done_cyc = -100;
  int         gap = -1;
  int         blk_idx = 0;
  int         resp_budget = 0;
  int         cd = 0;
  int         s0 = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  logic       busy = 1'b0;
  logic [7:0] held = '0;

  localparam logic [127:0] B0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BG = 128'h3C0102030405060708090A0B0C0D0EC3;

  // Transmission order of block byte i, straight from the byte-order rule
  function automatic logic [7:0] bsel(input logic [127:0] b, input int i);
`ifdef TX_BUFFER_LSB_FIRST_EN
    return b[8*i +: 8];
`else
    return b[8*(15-i) +: 8];
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Compare process: every tx_start byte against the expected stream, byte held until tx_done
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      busy    = 1'b0;
      blk_idx = 0;
    end else begin
      if (busy) chk("byte_stable", 128'(byte_out), 128'(held));
      if (busy && tx_done) begin
        busy          = 1'b0;
        last_done_cyc = cyc;
      end
      if (tx_start) begin
        chk("start_after_done", 128'(busy), 128'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_start: got byte %0h expected no transmission", byte_out);
        end else begin
          chk("tx_byte", 128'(byte_out), 128'(exp_q.pop_front()));
        end
        if (blk_idx == 0) gap = cyc - last_done_cyc;
        blk_idx = (blk_idx + 1) % 16;
        starts_total++;
        got.push_back(byte_out);
        held = byte_out;
        busy = 1'b1;
      end
    end
  end

  // UART model: answers tx_start with tx_done three cycles later while budget remains
  initial forever begin
    @(posedge clk);
    #1;
    done_resp = 1'b0;
    if (!reset) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) done_resp = 1'b1;
      end
      if (tx_start && resp_budget > 0) begin
        cd = 3;
        resp_budget--;
      end
    end
  end

  task automatic push(input logic [127:0] d, input bit acc);
    blk_in   = d;
    write_en = 1'b1;
    if (acc) for (int i = 0; i < 16; i++) exp_q.push_back(bsel(d, i));
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic pulse_done();
    done_man = 1'b1;
    @(posedge clk);
    #1;
    done_man = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (idle && exp_q.size() == 0) ok = 1'b1;
    end
    if (ok) checks++;
    else timeout(name);
  endtask

  // Waits for the tx_start that follows exactly n earlier starts
  task automatic wait_start(input int n, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (tx_start && starts_total == n) ok = 1'b1;
    end
    if (!ok) timeout(name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_full", 128'(full), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_tx_start", 128'(tx_start), 128'd0);
    chk("rst_idle", 128'(idle), 128'd1);
    chk("rst_byte", 128'(byte_out), 128'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single block, latency and byte order
    got.delete();
    resp_budget = INF;
    s0 = starts_total;
    push(B0, 1'b1);
    chk("latency_edge_n", 128'(tx_start), 128'd0);
    @(posedge clk);
    #1;
    chk("latency_edge_n1", 128'(tx_start), 128'd1);
    wait_idle("single_block_idle");
    chk("single_block_starts", 128'(starts_total - s0), 128'd16);
`ifdef TX_BUFFER_LSB_FIRST_EN
    chk("lit_byte0", 128'(got[0]), 128'h00FF);
    chk("lit_byte1", 128'(got[1]), 128'h00EE);
    chk("lit_byte15", 128'(got[15]), 128'h0000);
`else
    chk("lit_byte0", 128'(got[0]), 128'h0000);
    chk("lit_byte1", 128'(got[1]), 128'h0011);
    chk("lit_byte15", 128'(got[15]), 128'h00FF);
`endif

    // Push and pop in the same edge with two blocks stored
    resp_budget = 15;
    s0 = starts_total;
    push(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b1);
    push(128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 1'b1);
    push(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 1'b1);
    wait_start(s0 + 15, "pushpop_16th_start");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    done_man = 1'b1;
    @(posedge clk);
    #1;
    done_man    = 1'b0;
    resp_budget = INF;
    push(128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF, 1'b1);
    chk("pushpop_full", 128'(full), 128'd0);
    chk("pushpop_overflow", 128'(overflow), 128'd0);
    wait_idle("pushpop_idle");
    chk("pushpop_starts", 128'(starts_total - s0), 128'd64);
    chk("back_to_back_gap", 128'(gap), 128'd2);

    // tx_done in IDLE and START is ignored
    resp_budget = 0;
    s0 = starts_total;
    pulse_done();
    chk("done_in_idle_idle", 128'(idle), 128'd1);
    push(128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF, 1'b1);
    @(posedge clk);
    #1;
    chk("ign_start_cycle", 128'(tx_start), 128'd1);
    pulse_done();
    chk("ign_wait_no_start", 128'(tx_start), 128'd0);
    chk("ign_byte0_kept", 128'(byte_out), 128'(bsel(128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF, 0)));
    resp_budget = INF;
    pulse_done();
    wait_idle("ignore_idle");
    chk("ignore_starts", 128'(starts_total - s0), 128'd16);

    // Fill to full with tx_done held low, then overflow
    resp_budget = 0;
    s0 = starts_total;
    push(128'h11111111111111111111111111111101, 1'b1);
    push(128'h22222222222222222222222222222202, 1'b1);
    push(128'h33333333333333333333333333333303, 1'b1);
    push(128'h44444444444444444444444444444404, 1'b1);
    chk("fill_not_full", 128'(full), 128'd0);
    push(128'h55555555555555555555555555555505, 1'b1);
    chk("fill_full", 128'(full), 128'd1);
    chk("fill_no_overflow", 128'(overflow), 128'd0);
    push(128'h66666666666666666666666666666606, 1'b0);
    chk("fill_overflow", 128'(overflow), 128'd1);
    chk("fill_still_full", 128'(full), 128'd1);
    resp_budget = INF;
    pulse_done();
    wait_idle("overflow_drain_idle");
    chk("overflow_sticky", 128'(overflow), 128'd1);
    chk("overflow_starts", 128'(starts_total - s0), 128'd80);

    // Reset after the fifth byte aborts the block
    s0 = starts_total;
    push(128'h77777777777777777777777777777707, 1'b1);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
        @(posedge clk);
        #1;
        if (tx_done && starts_total == s0 + 5) ok = 1'b1;
      end
      if (!ok) timeout("abort_fifth_done");
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_tx_start", 128'(tx_start), 128'd0);
    chk("abort_idle", 128'(idle), 128'd1);
    chk("abort_byte", 128'(byte_out), 128'd0);
    chk("abort_overflow_clr", 128'(overflow), 128'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    got.delete();
    s0 = starts_total;
    push(BG, 1'b1);
    wait_idle("after_abort_idle");
    chk("after_abort_starts", 128'(starts_total - s0), 128'd16);
`ifdef TX_BUFFER_LSB_FIRST_EN
    chk("after_abort_first", 128'(got[0]), 128'h00C3);
`else
    chk("after_abort_first", 128'(got[0]), 128'h003C);
`endif
    chk("exp_stream_drained", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_block_buffer.md
TX_BLOCK_BUFFER -- requirements
Module: tx_block_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 128-bit block entries in the FIFO (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port block_aes_to_buffer, input, 128 bits: ciphertext block from the AES core.
REQ-005 SHALL have port write_en, input, 1 bit: push block_aes_to_buffer into the FIFO this cycle.
REQ-006 SHALL have port full, output, 1 bit: the FIFO holds DEPTH entries.
REQ-007 SHALL have port overflow, output, 1 bit: sticky flag; a write was attempted while full.
REQ-008 SHALL have port byte_shiftReg_to_UART_tx, output, 8 bits: byte currently presented to the UART transmitter.
REQ-009 SHALL have port tx_start, output, 1 bit: one-cycle pulse; UART transmitter accepts byte_shiftReg_to_UART_tx.
REQ-010 SHALL have port tx_done, input, 1 bit: one-cycle pulse from the UART transmitter; the byte has been sent.
REQ-011 SHALL have port idle, output, 1 bit: FIFO empty and the serialiser in IDLE.

Function
REQ-012 FIFO: a write with write_en=1 and full=0 SHALL store the block at the tail; the FIFO SHALL preserve order; pointers SHALL wrap modulo DEPTH.
REQ-013 A write with write_en=1 and full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-014 A simultaneous push and pop in a non-full FIFO SHALL both take effect, leaving the occupancy unchanged.
REQ-015 The serialiser FSM SHALL have the states IDLE, START and WAIT.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop the head block into a 128-bit shift register, clear the 4-bit byte counter, and go to START on that edge.
REQ-017 In START, tx_start SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT.
REQ-018 In WAIT on tx_done=1: if byte_cnt=15, the FSM SHALL go to IDLE; otherwise it SHALL shift the register 8 bits, increment byte_cnt, and go to START.
REQ-019 Byte order: byte_shiftReg_to_UART_tx SHALL be register bits [127:120], and shifting SHALL be to the left, so block bits [127:120] are sent first.
REQ-020 tx_done outside WAIT SHALL be ignored.
REQ-021 byte_shiftReg_to_UART_tx SHALL be stable from START until tx_done is seen.
REQ-022 Latency: a write into an empty FIFO with the FSM in IDLE at edge N SHALL give tx_start=1 in the cycle after edge N+1.
REQ-023 Back-to-back blocks SHALL have no extra gap: after the 16th tx_done, the FSM SHALL pass through IDLE for exactly one cycle, then reach START.
REQ-024 Exactly 16 tx_start pulses SHALL be issued per block popped.

Reset
REQ-025 With reset=0, the FIFO SHALL be asynchronously emptied, full=0, overflow=0, the FSM in IDLE, byte_cnt=0, the shift register 0, tx_start=0 and idle=1.
REQ-026 Reset mid-block SHALL abort the block; the remaining bytes SHALL be discarded and SHALL NOT be resumed.
REQ-027 overflow SHALL clear only on reset.

Configuration
REQ-028 With TX_BUFFER_LSB_FIRST_EN defined, the output byte SHALL be register bits [7:0] and shifting SHALL be to the right (block bits [7:0] sent first).
REQ-029 With TX_BUFFER_LSB_FIRST_EN undefined, the MSB-first behaviour of REQ-019 SHALL apply.

Structure
REQ-030 Package tx_buffer_pkg SHALL hold BLOCK_W=128, BYTE_W=8, BYTES_PER_BLOCK=16 and the FSM state encoding (IDLE, START, WAIT).
REQ-031 One sub-module, tx_shift, SHALL contain the shift register, byte_cnt and the FSM; the FIFO storage and pointers SHALL reside in tx_block_buffer.

Verification
REQ-032 Write 0x00112233445566778899AABBCCDDEEFF and answer each tx_start with tx_done 3 cycles later -> bytes 0x00,0x11,...,0xFF in order, 16 tx_start pulses, then idle=1.
REQ-033 Same block with TX_BUFFER_LSB_FIRST_EN defined -> bytes 0xFF,0xEE,...,0x00.
REQ-034 DEPTH=4, tx_done held 0, 5 writes -> full=1 after the 4th accepted block (one block popped to the serialiser), overflow=1 after the 6th write attempt; the dropped block is never transmitted.
REQ-035 Push and pop in the same cycle with 2 entries stored -> occupancy stays 2 and no data loss over 3 blocks.
REQ-036 Assert reset=0 after the 5th byte of a block -> tx_start=0 and idle=1 immediately; after release with a new write, the first byte is the new block's byte 0.
REQ-037 tx_done pulsed in IDLE and START -> ignored: no shift, and byte_cnt unchanged.
